// File: rtl/mem_sys_pkg.sv
// mem_sys_pkg: shared state type, line geometry and address-field helpers
// Exports: state_t (IDLE/WB/ALLOC/DONE), MEM_LAT, WORDS, OFF_BITS, ADDR_BITS, tag_bits()
package mem_sys_pkg;
    typedef enum logic [1:0] {IDLE, WB, ALLOC, DONE} state_t;
    localparam int MEM_LAT   = 2;
    localparam int WORDS     = 4;
    localparam int OFF_BITS  = 2;
    localparam int ADDR_BITS = 16;
    // byte address = {tag, index, word offset, byte bit}
    function automatic int tag_bits(input int index_bits);
        return ADDR_BITS - 1 - OFF_BITS - index_bits;
    endfunction
endpackage

// File: rtl/dm_cache_ctrl_if.sv
// dm_cache_ctrl_if: requester and backing-memory signals of the cache controller
// master: requester + memory model (drives Addr/DataIn/Rd/Wr/mem_rdata)
// slave : controller (drives DataOut/Done/Stall/CacheHit/err and the mem_* issue side)
interface dm_cache_ctrl_if;
    logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
    logic        Rd, Wr, Done, Stall, CacheHit, err, mem_rd, mem_wr;
    modport master (
        output Addr, DataIn, Rd, Wr, mem_rdata,
        input  DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );
    modport slave (
        input  Addr, DataIn, Rd, Wr, mem_rdata,
        output DataOut, Done, Stall, CacheHit, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/cache_array.sv
// cache_array: valid/dirty/tag arrays and 4-word data lines, one shared line index
// Ports: idx_i selects the line; valid_o/dirty_o/tag_o/line_o read it combinationally;
//        word_we_i/word_i write words, tag_we_i writes tag and sets valid, dirty_we_i/dirty_i update dirty
module cache_array
    import mem_sys_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = tag_bits(INDEX_BITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  idx_i,
    output logic                   valid_o,
    output logic                   dirty_o,
    output logic [TAG_BITS-1:0]    tag_o,
    output logic [WORDS-1:0][15:0] line_o,
    input  logic [WORDS-1:0]       word_we_i,
    input  logic [15:0]            word_i,
    input  logic                   tag_we_i,
    input  logic [TAG_BITS-1:0]    tag_i,
    input  logic                   dirty_we_i,
    input  logic                   dirty_i
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [LINES-1:0]       valid_q, dirty_q;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [WORDS-1:0][15:0] data_q [LINES];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    always_ff @(posedge clk)
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (tag_we_i) valid_q[idx_i] <= 1'b1;
            if (dirty_we_i) dirty_q[idx_i] <= dirty_i;
        end
    // tag and data contents are don't-care after reset, so they carry no reset
    always_ff @(posedge clk) begin
        if (tag_we_i) tag_q[idx_i] <= tag_i;
        for (int w = 0; w < WORDS; w++)
            if (word_we_i[w]) data_q[idx_i][w] <= word_i;
    end
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-back write-allocate cache controller
// Ports: clk, rst (sync, active high); bus (slave modport) carries the requester
//        side (Addr/DataIn/Rd/Wr -> DataOut/Done/Stall/CacheHit/err) and the
//        backing-memory side (mem_addr/mem_wdata/mem_rd/mem_wr <- mem_rdata)
module dm_cache_ctrl
    import mem_sys_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input logic            clk,
    input logic            rst,
    dm_cache_ctrl_if.slave bus
);
    localparam int         TAG_BITS = tag_bits(INDEX_BITS);
    localparam int         IDX_LSB  = 1 + OFF_BITS;
    localparam int         TAG_LSB  = IDX_LSB + INDEX_BITS;
    localparam logic [2:0] WB_LAST  = 3'(WORDS - 1);
    localparam logic [2:0] AL_LAST  = 3'(MEM_LAT + WORDS - 1);
    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic [15:1]            a_q;
    logic [15:0]            d_q;
    logic                   wr_q;
    logic                   idle, legal, hit, fill, valid, dirty;
    logic                   tag_we, dirty_we, wdirty;
    logic [1:0]             off, fsel;
    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]    tag, vtag;
    logic [WORDS-1:0][15:0] line;
    logic [WORDS-1:0]       word_we;
    logic [15:0]            word;
    assign idle  = state_q == IDLE;
    assign legal = idle & (bus.Rd ^ bus.Wr) & ~bus.Addr[0];
    // in IDLE the live request addresses the array, afterwards the latched copy does
    assign off   = idle ? bus.Addr[2:1] : a_q[2:1];
    assign idx   = idle ? bus.Addr[TAG_LSB-1:IDX_LSB] : a_q[TAG_LSB-1:IDX_LSB];
    assign tag   = idle ? bus.Addr[15:TAG_LSB] : a_q[15:TAG_LSB];
    assign hit   = legal & valid & (vtag == tag);
    // refill data trails the read issue by MEM_LAT cycles
    assign fill  = state_q == ALLOC && cnt_q >= 3'(MEM_LAT);
    assign fsel  = 2'(cnt_q - 3'(MEM_LAT));
    assign bus.Done      = hit | (state_q == DONE);
    assign bus.CacheHit  = hit;
    assign bus.Stall     = state_q == WB || state_q == ALLOC;
    assign bus.err       = idle & ((bus.Rd & bus.Wr) | ((bus.Rd | bus.Wr) & bus.Addr[0]));
    assign bus.mem_wr    = state_q == WB;
    assign bus.mem_rd    = state_q == ALLOC && cnt_q < 3'(WORDS);
    assign bus.mem_addr  = bus.mem_wr ? {vtag, idx, cnt_q[1:0], 1'b0} :
                           bus.mem_rd ? {tag, idx, cnt_q[1:0], 1'b0} : '0;
    assign bus.mem_wdata = bus.mem_wr ? line[cnt_q[1:0]] : '0;
    assign bus.DataOut   = (hit & bus.Rd) | (state_q == DONE & ~wr_q) ? line[off] : '0;
    always_comb begin
        word_we  = '0;
        word     = fill ? bus.mem_rdata : idle ? bus.DataIn : d_q;
        tag_we   = state_q == ALLOC && cnt_q == AL_LAST;
        dirty_we = tag_we | (hit & bus.Wr) | (state_q == DONE & wr_q);
        wdirty   = !tag_we;
        if (fill) word_we[fsel] = 1'b1;
        if ((hit & bus.Wr) | (state_q == DONE & wr_q)) word_we[off] = 1'b1;
    end
    cache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx_i      (idx),
        .valid_o    (valid),
        .dirty_o    (dirty),
        .tag_o      (vtag),
        .line_o     (line),
        .word_we_i  (word_we),
        .word_i     (word),
        .tag_we_i   (tag_we),
        .tag_i      (tag),
        .dirty_we_i (dirty_we),
        .dirty_i    (wdirty)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else
            case (state_q)
                IDLE:
                    if (legal && !hit) begin
                        a_q     <= bus.Addr[15:1];
                        d_q     <= bus.DataIn;
                        wr_q    <= bus.Wr;
                        cnt_q   <= '0;
                        state_q <= valid && dirty ? WB : ALLOC;
                    end
                WB: begin
                    cnt_q   <= cnt_q == WB_LAST ? '0 : cnt_q + 3'd1;
                    state_q <= cnt_q == WB_LAST ? ALLOC : WB;
                end
                ALLOC: begin
                    cnt_q   <= cnt_q == AL_LAST ? '0 : cnt_q + 3'd1;
                    state_q <= cnt_q == AL_LAST ? DONE : ALLOC;
                end
                default: state_q <= IDLE;
            endcase
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed checks of hits, clean/dirty misses, illegal requests and reset abort
module tb_dm_cache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] mem [0:32767];
    logic [15:0] p1, p2;
    dm_cache_ctrl_if bus ();
    dm_cache_ctrl #(.INDEX_BITS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign bus.mem_rdata = p2;
    // backing memory: fixed 2-cycle read latency, preloaded while rst is high
    always @(posedge clk) begin
        p1 <= bus.mem_rd ? mem[bus.mem_addr[15:1]] : 16'h0;
        p2 <= p1;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[15'(16'h0008 + i)] <= 16'(16'hA0 + i);
                mem[15'(16'h0408 + i)] <= 16'(16'hC0 + i);
                mem[15'(16'h0080 + i)] <= 16'(16'hD0 + i);
                mem[15'(16'h0480 + i)] <= 16'(16'hE0 + i);
            end
        end else if (bus.mem_wr)
            mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
    end
    function automatic logic [53:0] pk(input logic d, s, h, e, r, w, input logic [15:0] q, a, wd);
        return {d, s, h, e, r, w, q, a, wd};
    endfunction
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string t, input logic [53:0] exp);
        logic [53:0] obs;
        #4;
        obs = {bus.Done, bus.Stall, bus.CacheHit, bus.err, bus.mem_rd, bus.mem_wr,
               bus.DataOut, bus.mem_addr, bus.mem_wdata};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (Done,Stall,Hit,err,rd,wr|DataOut|mem_addr|mem_wdata)", t, obs, exp);
        end
    endtask
    // follows a miss from T+1: optional 4-cycle write-back, 6-cycle refill, then DONE
    task automatic miss_seq(input string t, input logic dirty, input logic [15:0] vbase,
                            input logic [63:0] vw, input logic [15:0] nbase, input logic [15:0] dout);
        if (dirty)
            for (int k = 0; k < 4; k++) begin
                nxt();
                chk($sformatf("%s_wb%0d", t, k), pk(0, 1, 0, 0, 0, 1, 0, vbase + 16'(2 * k), vw[16 * (3 - k) +: 16]));
            end
        for (int k = 0; k < 6; k++) begin
            nxt();
            chk($sformatf("%s_alloc%0d", t, k),
                pk(0, 1, 0, 0, k < 4, 0, 0, k < 4 ? nbase + 16'(2 * k) : 16'h0, 0));
        end
        nxt();
        chk({t, "_done"}, pk(1, 0, 0, 0, 0, 0, dout, 0, 0));
    endtask
    initial begin
        bus.Addr = 16'h0;
        bus.DataIn = 16'h0;
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        nxt(); bus.Rd = 1'b1; bus.Addr = 16'h0010;
        chk("rd10_req", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        miss_seq("rd10", 1'b0, 16'h0, 64'h0, 16'h0010, 16'h00A0);
        nxt(); bus.Addr = 16'h0014;
        chk("rd14_hit", pk(1, 0, 1, 0, 0, 0, 16'h00A2, 0, 0));
        nxt(); bus.Rd = 1'b0; bus.Wr = 1'b1; bus.Addr = 16'h0012; bus.DataIn = 16'hBEEF;
        chk("wr12_hit", pk(1, 0, 1, 0, 0, 0, 0, 0, 0));
        nxt(); bus.Rd = 1'b1; bus.Wr = 1'b0; bus.Addr = 16'h0812;
        chk("rd812_req", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        miss_seq("rd812", 1'b1, 16'h0010, 64'h00A0_BEEF_00A2_00A3, 16'h0810, 16'h00C1);
        nxt(); bus.Rd = 1'b0; bus.Wr = 1'b1; bus.Addr = 16'h0100; bus.DataIn = 16'h1234;
        chk("wr100_req", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        miss_seq("wr100", 1'b0, 16'h0, 64'h0, 16'h0100, 16'h0000);
        nxt(); bus.Rd = 1'b1; bus.Wr = 1'b0;
        chk("rd100_hit", pk(1, 0, 1, 0, 0, 0, 16'h1234, 0, 0));
        nxt(); bus.Addr = 16'h0900;
        chk("rd900_req", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        miss_seq("rd900", 1'b1, 16'h0100, 64'h1234_00D1_00D2_00D3, 16'h0900, 16'h00E0);
        nxt(); bus.Wr = 1'b1; bus.Addr = 16'h0812; bus.DataIn = 16'hFFFF;
        chk("err_rdwr", pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        nxt(); bus.Wr = 1'b0; bus.Addr = 16'h0003;
        chk("err_odd", pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        nxt(); bus.Addr = 16'h0812;
        chk("rd812_unchanged", pk(1, 0, 1, 0, 0, 0, 16'h00C1, 0, 0));
        nxt(); bus.Addr = 16'h0200;
        chk("rd200_req", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        nxt();
        chk("rd200_alloc0", pk(0, 1, 0, 0, 1, 0, 0, 16'h0200, 0));
        nxt();
        chk("rd200_alloc1", pk(0, 1, 0, 0, 1, 0, 0, 16'h0202, 0));
        nxt(); rst = 1'b1;
        chk("rd200_alloc2", pk(0, 1, 0, 0, 1, 0, 0, 16'h0204, 0));
        nxt(); rst = 1'b0; bus.Rd = 1'b0;
        chk("abort_idle", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        nxt(); bus.Rd = 1'b1; bus.Addr = 16'h0812;
        chk("rd812_after_rst", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        miss_seq("rd812b", 1'b0, 16'h0, 64'h0, 16'h0810, 16'h00C1);
        for (int i = 0; i < 16; i++) begin
            nxt(); bus.Addr = 16'(16'h0810 + 2 * (i % 4));
            chk($sformatf("b2b_hit%0d", i), pk(1, 0, 1, 0, 0, 0, 16'(16'h00C0 + i % 4), 0, 0));
        end
        nxt(); bus.Rd = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Direct-mapped, write-back, write-allocate cache controller that is the responder to the pipelined processor's fetch and memory stages. It accepts one word request at a time, completes hits in the request cycle, and stalls the requester on misses while it refills from a 4-bank backing memory with fixed read latency. On dirty misses it first writes the victim line back. It owns the tag, valid, dirty and data arrays.

## Interface
- INDEX_BITS, 8, number of index bits; the cache holds 2^INDEX_BITS lines of 4 × 16-bit words
- TAG_BITS, 16-3-INDEX_BITS (5), derived tag width, not overridable
- MEM_LAT, 2, backing-memory read latency in cycles; fixed, not overridable
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- Addr  in  16  requester byte address; Addr[2:1] = word offset, Addr[2+INDEX_BITS:3] = index, upper bits = tag
- DataIn  in  16  write data
- Rd  in  1  read request
- Wr  in  1  write request
- DataOut  out  16  read data; valid only while Done=1 for a read
- Done  out  1  request complete in this cycle
- Stall  out  1  controller busy; requester must hold Addr/DataIn/Rd/Wr stable
- CacheHit  out  1  with Done: 1 = hit, 0 = completed via refill
- err  out  1  illegal request flag
- mem_addr  out  16  backing-memory byte address, word aligned
- mem_wdata  out  16  backing-memory write data
- mem_rd  out  1  backing-memory read issue
- mem_wr  out  1  backing-memory write issue
- mem_rdata  in  16  read data, valid exactly MEM_LAT cycles after the mem_rd issue

## Operation
- States: IDLE, WB, ALLOC, DONE. A 3-bit counter `cnt` sequences WB and ALLOC.
- IDLE with Rd^Wr and Addr[0]=0: look up the index.
  - Hit (valid and tag match): Done=1, CacheHit=1, Stall=0 in the same cycle (combinational).
    - Read: DataOut = stored word.
    - Write: the word is updated and dirty is set at the clock edge.
  - Miss: latch Addr, DataIn and Rd/Wr, then go to WB if the victim is valid and dirty, otherwise go to ALLOC; cnt=0.
- Illegal request in IDLE (Rd&Wr, or Addr[0]=1 with Rd|Wr):
  - err=1 combinationally for that cycle.
  - No array change, Done=0, state stays IDLE.
- WB, cnt 0..3:
  - Drive mem_wr=1, mem_addr={victim tag, index, cnt[1:0], 1'b0}, mem_wdata=victim word cnt.
  - At cnt=3, go to ALLOC with cnt=0.
- ALLOC, cnt 0..5:
  - cnt<4: drive mem_rd=1, mem_addr={latched tag, index, cnt[1:0], 1'b0}.
  - cnt>=2: capture mem_rdata into line word cnt-2.
  - At cnt=5: write the new tag, valid=1, dirty=0, then go to DONE.
- DONE, one cycle: Done=1, CacheHit=0, Stall=0.
  - Read: DataOut = the refilled word at the latched offset.
  - Write: merge the latched DataIn into the line and set dirty at the edge.
  - Next state is IDLE.
- Stall=1 in WB and ALLOC only. Rd/Wr/Addr inputs are ignored outside IDLE; the latched copy is authoritative.
- Outside the cases above, DataOut is 0 and mem_addr/mem_wdata are 0.

## Timing
- Reset (synchronous):
  - state=IDLE, cnt=0.
  - All valid and dirty bits cleared; data and tag contents are don't-care.
  - All outputs 0 in the cycle after reset: Done, Stall, CacheHit, err, mem_rd, mem_wr, DataOut, mem_addr, mem_wdata.
- Hit latency: 0 cycles (Done in the request cycle).
- Clean miss: request at cycle T, ALLOC T+1..T+6, Done at T+7.
- Dirty miss: WB T+1..T+4, ALLOC T+5..T+10, Done at T+11.
- mem_rd and mem_wr are never asserted in the same cycle.
- Reset during WB or ALLOC aborts the operation:
  - Next cycle is IDLE with all lines invalid.
  - No Done is issued.
  - A partial write-back is not completed.
- A new request may be presented in the cycle after DONE. Back-to-back hits complete one per cycle.

## Structure
- Package `mem_sys_pkg` holds:
  - state enum (IDLE, WB, ALLOC, DONE)
  - MEM_LAT and words-per-line constant (4)
  - address field slicing helpers (tag/index/offset widths)
- Sub-module `cache_array` holds the valid/dirty/tag arrays and the 4-word data line per index.
  - One read port.
  - One write port with per-word enable, plus tag/valid/dirty update.
  - Synchronous clear of valid/dirty on rst.
- The controller holds the FSM, the counter, the request latch and the memory-side muxing.

## Test plan
- After reset, Rd at Addr 0x0010 → Stall for T+1..T+6, mem_rd addresses 0x0010, 0x0012, 0x0014, 0x0016; backing returns 0xA0..0xA3 → Done, CacheHit=0, DataOut=0xA0 at T+7. Re-read 0x0014 → Done and CacheHit=1, DataOut=0xA2 in the same cycle.
- Wr 0x0012 with DataIn 0xBEEF (hit) → Done, CacheHit=1. Then Rd at 0x0812 (same index, different tag) → WB writes 0xA0, 0xBEEF, 0xA2, 0xA3 to 0x0010..0x0016, then ALLOC, then Done at T+11.
- Wr miss at 0x0100 with DataIn 0x1234 → refill, then DONE merges 0x1234. A following Rd 0x0100 hits with 0x1234, and the line is marked dirty (its eviction causes a WB).
- Rd=Wr=1, and separately Rd with Addr=0x0003 → err=1 that cycle, Done=0, no mem_rd/mem_wr, array unchanged.
- rst asserted at ALLOC cnt=2 → next cycle IDLE, all outputs 0. A re-read of the same address misses.
- 16 back-to-back read hits → 16 consecutive Done cycles, Stall=0 throughout.
